screen_write_ctrl: RTL and testbench

//  Sequencer between the UART receiver and the character screen buffer. Parses the
//  4-byte packet stream (col, row, char, terminator) into single-cycle buffer writes,

---
 rtl/screen_write_ctrl_if.sv | 34 +++
 rtl/screen_write_ctrl.sv | 170 +++++++++++++++++
 tb/tb_screen_write_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/screen_write_ctrl_if.sv
// rtl/screen_write_ctrl_if.sv - UART byte input and screen buffer write port bundle
interface screen_write_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       wr_en;
    logic [7:0] col_w;
    logic [5:0] row_w;
    logic [6:0] din;
    logic       busy;
    logic       err;

    // master: the sequencer that owns the buffer write port
    modport master (
        input  rx_valid,
        input  rx_data,
        output wr_en,
        output col_w,
        output row_w,
        output din,
        output busy,
        output err
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  wr_en,
        input  col_w,
        input  row_w,
        input  din,
        input  busy,
        input  err
    );
endinterface

// File: rtl/screen_write_ctrl.sv
// rtl/screen_write_ctrl.sv - packet parser and full-screen clear sequencer for the character buffer
module screen_write_ctrl #(
    parameter int         N_COL          = 160,
    parameter int         N_ROW          = 64,
    parameter logic [6:0] CLEAR_CHAR     = 7'h20,
    parameter logic [7:0] CLEAR_CMD      = 8'hFF,
    parameter int         TIMEOUT_CYCLES = 200000
) (
    input  logic                 clk108,
    input  logic                 rst_n,
    screen_write_ctrl_if.master  bus
);

    localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] N_COL_B  = 8'(N_COL);
    localparam logic [7:0] COL_LAST = 8'(N_COL - 1);
    localparam logic [5:0] ROW_LAST = 6'(N_ROW - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_COL,
        S_ROW,
        S_CHAR,
        S_TERM,
        S_CLEAR
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    col_q, col_d;
    logic [5:0]    row_q, row_d;
    logic [6:0]    din_q, din_d;
    logic          wr_en_q, wr_en_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          rx_prev_q;
    logic [1:0]    rst_sync_q;
    logic          rst_n_s;
    logic          accept;

    // Assertion reaches every flop at once; release is aligned to clk108.
    always_ff @(posedge clk108 or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_q[1];

    always_ff @(posedge clk108 or negedge rst_n_s) begin
        if (!rst_n_s) begin
            rx_prev_q <= 1'b0;
        end else begin
            rx_prev_q <= bus.rx_valid;
        end
    end

    assign accept = bus.rx_valid & ~rx_prev_q;

    always_ff @(posedge clk108 or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q <= S_COL;
            col_q   <= '0;
            row_q   <= '0;
            din_q   <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            din_q   <= din_d;
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        din_d   = din_q;
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = '0;
        case (state_q)
            S_COL: begin
                if (accept) begin
                    if (bus.rx_data == CLEAR_CMD) begin
                        state_d = S_CLEAR;
                        col_d   = '0;
                        row_d   = '0;
                        din_d   = CLEAR_CHAR;
                        wr_en_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        col_d   = (bus.rx_data >= N_COL_B) ? bus.rx_data - N_COL_B : bus.rx_data;
                        state_d = S_ROW;
                    end
                end
            end
            S_ROW, S_CHAR, S_TERM: begin
                // An accepted byte always beats a timeout expiring in the same cycle.
                if (accept) begin
                    case (state_q)
                        S_ROW: begin
                            if (bus.rx_data[7:6] != 2'b00) begin
                                err_d   = 1'b1;
                                state_d = S_COL;
                            end else begin
                                row_d   = bus.rx_data[5:0];
                                state_d = S_CHAR;
                            end
                        end
                        S_CHAR: begin
                            din_d   = bus.rx_data[6:0];
                            wr_en_d = 1'b1;
                            state_d = S_TERM;
                        end
                        default: begin
                            err_d   = (bus.rx_data != 8'h0A);
                            state_d = S_COL;
                        end
                    endcase
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_COL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CLEAR: begin
                // Bytes are discarded for the whole clear, including its final tile.
                err_d = accept;
                if (col_q == COL_LAST && row_q == ROW_LAST) begin
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_COL;
                end else begin
                    wr_en_d = 1'b1;
                    busy_d  = 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_COL;
            end
        endcase
    end

    assign bus.wr_en = wr_en_q;
    assign bus.col_w = col_q;
    assign bus.row_w = row_q;
    assign bus.din   = din_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_screen_write_ctrl.sv
// tb/tb_screen_write_ctrl.sv - directed vector bench for screen_write_ctrl
module tb_screen_write_ctrl;

    localparam int TO = 50;

    logic clk108 = 1'b0;
    logic rst_n  = 1'b0;

    screen_write_ctrl_if bus ();

    screen_write_ctrl #(
        .N_COL(160), .N_ROW(64), .CLEAR_CHAR(7'h20), .CLEAR_CMD(8'hFF), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk108(clk108),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk108 = ~clk108;

    typedef struct packed {
        logic [7:0] c;
        logic [5:0] r;
        logic [6:0] d;
        logic       b;
    } wr_t;

    typedef struct packed {
        int              nb;
        logic [0:5][7:0] bytes;
        int              nw;
        logic [7:0]      c;
        logic [5:0]      r;
        logic [6:0]      d;
        int              ne;
    } vec_t;

    wr_t  writes[$];
    int   err_cnt = 0;
    int   checks  = 0;
    int   errors  = 0;
    vec_t vecs[8];

    always @(negedge clk108) begin
        if (bus.wr_en) writes.push_back('{c: bus.col_w, r: bus.row_w, d: bus.din, b: bus.busy});
        if (bus.err) err_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(posedge clk108);
        #1;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        repeat (hold) @(posedge clk108);
        #1;
        bus.rx_valid = 1'b0;
        repeat (3) @(posedge clk108);
    endtask

    task automatic clear_log();
        @(negedge clk108);
        writes.delete();
        err_cnt = 0;
    endtask

    task automatic check_packet(input string name, input logic [7:0] c, input logic [5:0] r,
                                input logic [6:0] d, input int ne);
        repeat (3) @(negedge clk108);
        check({name, " writes"}, writes.size(), 1);
        if (writes.size() > 0)
            check({name, " data"}, {writes[$].c, writes[$].r, writes[$].d}, {c, r, d});
        check({name, " err"}, err_cnt, ne);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        vecs[0] = '{nb: 4, bytes: {8'h05, 8'h03, 8'h41, 8'h0A, 8'h00, 8'h00}, nw: 1, c: 8'd5,   r: 6'd3,  d: 7'h41, ne: 0};
        vecs[1] = '{nb: 4, bytes: {8'h9F, 8'h3F, 8'h7E, 8'h0A, 8'h00, 8'h00}, nw: 1, c: 8'd159, r: 6'd63, d: 7'h7E, ne: 0};
        vecs[2] = '{nb: 4, bytes: {8'hA0, 8'h01, 8'h44, 8'h0A, 8'h00, 8'h00}, nw: 1, c: 8'd0,   r: 6'd1,  d: 7'h44, ne: 0};
        vecs[3] = '{nb: 4, bytes: {8'hFE, 8'h05, 8'h20, 8'h0A, 8'h00, 8'h00}, nw: 1, c: 8'd94,  r: 6'd5,  d: 7'h20, ne: 0};
        vecs[4] = '{nb: 4, bytes: {8'h10, 8'h02, 8'h43, 8'h0D, 8'h00, 8'h00}, nw: 1, c: 8'd16,  r: 6'd2,  d: 7'h43, ne: 1};
        vecs[5] = '{nb: 6, bytes: {8'hA5, 8'h40, 8'h07, 8'h08, 8'h45, 8'h0A}, nw: 1, c: 8'd7,   r: 6'd8,  d: 7'h45, ne: 1};
        vecs[6] = '{nb: 6, bytes: {8'h01, 8'h80, 8'h02, 8'h03, 8'h46, 8'h0A}, nw: 1, c: 8'd2,   r: 6'd3,  d: 7'h46, ne: 1};
        vecs[7] = '{nb: 4, bytes: {8'hA5, 8'h00, 8'hC1, 8'h0A, 8'h00, 8'h00}, nw: 1, c: 8'd5,   r: 6'd0,  d: 7'h41, ne: 0};

        repeat (4) @(posedge clk108);
        #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk108);
        check("reset outputs", {bus.wr_en, bus.col_w, bus.row_w, bus.din, bus.busy, bus.err}, '0);
        check("reset no err", err_cnt, 0);

        for (int i = 0; i < 8; i++) begin
            clear_log();
            for (int k = 0; k < vecs[i].nb; k++) send_byte(vecs[i].bytes[k], 3);
            repeat (3) @(negedge clk108);
            check($sformatf("vec%0d writes", i), writes.size(), vecs[i].nw);
            if (writes.size() > 0)
                check($sformatf("vec%0d data", i), {writes[$].c, writes[$].r, writes[$].d},
                      {vecs[i].c, vecs[i].r, vecs[i].d});
            check($sformatf("vec%0d err", i), err_cnt, vecs[i].ne);
            check($sformatf("vec%0d hold", i), {bus.col_w, bus.row_w, bus.din},
                  {vecs[i].c, vecs[i].r, vecs[i].d});
        end

        // rx_valid held high for a long time counts as a single byte
        clear_log();
        send_byte(8'h03, 40); send_byte(8'h04, 40); send_byte(8'h48, 40); send_byte(8'h0A, 40);
        check_packet("held valid", 8'd3, 6'd4, 7'h48, 0);

        // full-screen clear with one stray byte in the middle
        begin
            int bad = 0;
            int nb  = 0;
            int cyc = 0;
            clear_log();
            send_byte(8'hFF, 3);
            check("clear busy", bus.busy, 1'b1);
            repeat (2000) @(posedge clk108);
            send_byte(8'h33, 3);
            while (bus.busy && cyc < 12000) begin
                @(negedge clk108);
                cyc++;
            end
            check("clear done in time", (cyc < 12000), 1'b1);
            repeat (3) @(negedge clk108);
            check("clear count", writes.size(), 10240);
            foreach (writes[j]) begin
                if (writes[j] != '{c: 8'(j % 160), r: 6'(j / 160), d: 7'h20, b: 1'b1}) bad++;
                if (!writes[j].b) nb++;
            end
            check("clear raster", bad, 0);
            check("clear busy during writes", nb, 0);
            check("clear stray err", err_cnt, 1);
            check("clear end state", {bus.wr_en, bus.busy, bus.col_w, bus.row_w}, '0);
        end
        clear_log();
        send_byte(8'h0C, 3); send_byte(8'h0D, 3); send_byte(8'h49, 3); send_byte(8'h0A, 3);
        check_packet("after clear", 8'd12, 6'd13, 7'h49, 0);

        // stall between row and char bytes
        begin
            int cyc = 0;
            clear_log();
            send_byte(8'h05, 3);
            send_byte(8'h03, 3);
            while (err_cnt == 0 && cyc < 200) begin
                @(negedge clk108);
                cyc++;
            end
            check("timeout err", err_cnt, 1);
            check("timeout window", (cyc >= 40 && cyc <= 50), 1'b1);
            check("timeout no write", writes.size(), 0);
        end
        clear_log();
        send_byte(8'h06, 3); send_byte(8'h04, 3); send_byte(8'h47, 3); send_byte(8'h0A, 3);
        check_packet("after timeout", 8'd6, 6'd4, 7'h47, 0);

        // reset in the middle of a clear
        clear_log();
        send_byte(8'hFF, 3);
        repeat (5000) @(negedge clk108);
        check("mid clear busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("reset mid clear", {bus.wr_en, bus.col_w, bus.row_w, bus.din, bus.busy, bus.err}, '0);
        repeat (3) @(posedge clk108);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk108);
        check("reset held idle", {bus.wr_en, bus.busy}, '0);
        clear_log();
        send_byte(8'h0A, 3); send_byte(8'h0B, 3); send_byte(8'h4A, 3); send_byte(8'h0A, 3);
        check_packet("after reset", 8'd10, 6'd11, 7'h4A, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
